// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MUL/DIV sequencer, one bit per cycle, HI/LO result.
// Define MULDIV_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_cnt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dz_q, dz_d;

  logic                 accept;
  logic                 op_is_div;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rem_sh;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   acc_step;

`ifdef MULDIV_SIGNED_EN
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;
`else
  assign a_mag = op_a;
  assign b_mag = op_b;
`endif

  assign op_is_div = alu_cnt[0];
  assign accept    = start && (alu_cnt == 4'b1000 || alu_cnt == 4'b1001) &&
                     (state_q == IDLE || state_q == DONE);

  // MUL: upper half accumulates, lower half holds the multiplier being shifted out.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // DIV: upper half is the partial remainder, lower half dividend turning into quotient.
  assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff   = div_rem_sh - {1'b0, b_q};
  assign div_next   = div_diff[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign acc_step = is_div_q ? div_next : mul_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
`ifdef MULDIV_SIGNED_EN
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          is_div_d = op_is_div;
          cnt_d    = '0;
          dz_d     = 1'b0;
`ifdef MULDIV_SIGNED_EN
          neg_lo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
          neg_hi_d = op_is_div ? op_a[WIDTH-1] : (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`endif
          if (op_is_div && op_b == '0) begin
            state_d = DONE;
            lo_d    = '1;
            hi_d    = op_a;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            acc_d   = {{WIDTH{1'b0}}, (op_is_div ? a_mag : b_mag)};
            b_d     = op_is_div ? b_mag : a_mag;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = acc_step;
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef MULDIV_SIGNED_EN
          if (is_div_q) begin
            lo_d = neg_lo_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
            hi_d = neg_hi_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = neg_lo_q ? -acc_step : acc_step;
          end
`else
          {hi_d, lo_d} = acc_step;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign stall    = busy | accept;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed bench for muldiv_sequencer at WIDTH=16.
module tb_muldiv_sequencer;

  localparam int W = 16;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_cnt;
  logic [W-1:0] op_a, op_b;
  logic         stall, busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_cnt(alu_cnt),
    .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; drives the request for the current cycle and returns in cycle 1.
  task automatic issue(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    start = 1'b1; alu_cnt = code; op_a = a; op_b = b;
    #1;
    check({tag, " stall@accept"}, {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; alu_cnt = 4'b0000;
  endtask

  task automatic wait_done(input int n0, input string tag, output int n_out);
    int low = 0;
    n_out = n0;
    while (!done && n_out < 200) begin
      if (!stall) low++;
      @(posedge clk); #1;
      n_out++;
    end
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " stall gaps"}, low, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_cnt = 4'b0000; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset dz", {31'b0, div_zero}, 0);
    rst = 1'b0;
    next_cycle();
    check("idle stall", {31'b0, stall}, 0);

    issue(OP_MUL, 16'h012C, 16'h01F4, "mul300x500");
    check("mul300x500 busy", {31'b0, busy}, 1);
    wait_done(1, "mul300x500", n);
    check("mul300x500 latency", n, 17);
    check("mul300x500 hi", hi, 16'h0002);
    check("mul300x500 lo", lo, 16'h49F0);
    check("mul300x500 dz", {31'b0, div_zero}, 0);
    next_cycle();
    check("done pulse", {31'b0, done}, 0);
    check("hi held", hi, 16'h0002);
    check("lo held", lo, 16'h49F0);

    issue(OP_DIV, 16'd1000, 16'd7, "div1000/7");
    wait_done(1, "div1000/7", n);
    check("div1000/7 latency", n, 17);
    check("div1000/7 lo", lo, 16'h008E);
    check("div1000/7 hi", hi, 16'h0006);
    check("div1000/7 dz", {31'b0, div_zero}, 0);
    next_cycle();

    issue(OP_DIV, 16'h1234, 16'h0000, "div0");
    wait_done(1, "div0", n);
    check("div0 latency", n, 1);
    check("div0 lo", lo, 16'hFFFF);
    check("div0 hi", hi, 16'h1234);
    check("div0 dz", {31'b0, div_zero}, 1);
    next_cycle();
    check("div0 dz held", {31'b0, div_zero}, 1);
    issue(OP_MUL, 16'd3, 16'd4, "mul3x4");
    wait_done(1, "mul3x4", n);
    check("mul3x4 lo", lo, 16'h000C);
    check("mul3x4 hi", hi, 16'h0000);
    check("mul3x4 dz", {31'b0, div_zero}, 0);
    next_cycle();

    // Back-to-back: second request lands in the DONE cycle of the first.
    issue(OP_DIV, 16'd100, 16'd9, "div100/9");
    wait_done(1, "div100/9", n);
    check("div100/9 lo", lo, 16'h000B);
    check("div100/9 hi", hi, 16'h0001);
    issue(OP_MUL, 16'd5, 16'd6, "b2b mul5x6");
    wait_done(1, "b2b mul5x6", n);
    check("b2b latency", n, 17);
    check("b2b lo", lo, 16'd30);
    next_cycle();
    next_cycle();

    start = 1'b1; alu_cnt = 4'b0101; op_a = 16'd9; op_b = 16'd9;
    #1;
    check("bad op stall", {31'b0, stall}, 0);
    next_cycle();
    start = 1'b0; alu_cnt = 4'b0000;
    check("bad op busy", {31'b0, busy}, 0);
    check("bad op done", {31'b0, done}, 0);
    check("bad op lo", lo, 16'd30);

    issue(OP_MUL, 16'd7, 16'd9, "mul7x9");
    next_cycle(); next_cycle();
    start = 1'b1; alu_cnt = OP_DIV; op_a = 16'd100; op_b = 16'd3;
    next_cycle();
    start = 1'b0; alu_cnt = 4'b0000; op_a = 16'hAAAA; op_b = 16'h5555;
    wait_done(4, "mul7x9", n);
    check("mul7x9 latency", n, 17);
    check("mul7x9 lo", lo, 16'd63);
    check("mul7x9 hi", hi, 16'd0);
    next_cycle();

    issue(OP_MUL, 16'hFFFF, 16'hFFFF, "abort");
    repeat (7) next_cycle();
    check("abort busy before", {31'b0, busy}, 1);
    rst = 1'b1;
    #1;
    check("abort busy", {31'b0, busy}, 0);
    check("abort done", {31'b0, done}, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    next_cycle();
    issue(OP_MUL, 16'd2, 16'd3, "mul2x3");
    wait_done(1, "mul2x3", n);
    check("mul2x3 lo", lo, 16'h0006);
    check("mul2x3 hi", hi, 16'h0000);
    next_cycle();

    issue(OP_MUL, 16'hFFFA, 16'h0007, "mulFFFAx7");
    wait_done(1, "mulFFFAx7", n);
    check("mulFFFAx7 lo", lo, 16'hFFD6);
`ifdef MULDIV_SIGNED_EN
    check("mulFFFAx7 hi", hi, 16'hFFFF);
`else
    check("mulFFFAx7 hi", hi, 16'h0006);
`endif
    next_cycle();

    issue(OP_DIV, 16'hFFF9, 16'h0002, "divFFF9/2");
    wait_done(1, "divFFF9/2", n);
    check("divFFF9/2 latency", n, 17);
`ifdef MULDIV_SIGNED_EN
    check("divFFF9/2 lo", lo, 16'hFFFD);
    check("divFFF9/2 hi", hi, 16'hFFFF);
`else
    check("divFFF9/2 lo", lo, 16'h7FFC);
    check("divFFF9/2 hi", hi, 16'h0001);
`endif
    next_cycle();

    issue(OP_DIV, 16'h8000, 16'hFFFF, "div8000/FFFF");
    wait_done(1, "div8000/FFFF", n);
    check("div8000/FFFF dz", {31'b0, div_zero}, 0);
`ifdef MULDIV_SIGNED_EN
    check("div8000/FFFF lo", lo, 16'h8000);
    check("div8000/FFFF hi", hi, 16'h0000);
`else
    check("div8000/FFFF lo", lo, 16'h0000);
    check("div8000/FFFF hi", hi, 16'h8000);
`endif
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the MUL (alu_cnt 4'b1000) and DIV (alu_cnt 4'b1001) operations decoded by the ALU control.
- Accepts one operation at a time and runs shift-add multiply or restoring divide, one bit per cycle.
- Drives a stall to the pipeline while it runs, then returns the result through HI/LO outputs.

Parameters:
- WIDTH, 32, operand width in bits; also the number of iteration cycles. Must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request strobe, qualified by alu_cnt
- alu_cnt  input  4  ALU control code; only 4'b1000 (MUL) and 4'b1001 (DIV) are accepted
- op_a  input  WIDTH  multiplicand / dividend, sampled on the accepting edge
- op_b  input  WIDTH  multiplier / divisor, sampled on the accepting edge
- stall  output  1  pipeline freeze
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- div_zero  output  1  set when a DIV with op_b == 0 completes; held with the results
- hi  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
- lo  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient

Behaviour:
- Reset (async, rst=1): state=IDLE, iteration counter=0, busy=0, done=0, div_zero=0, hi=0, lo=0, internal accumulators=0.
- Clock and reset: one clock only; reset is asynchronous and active-high.
- States: IDLE, RUN, DONE.
- accept = start && (alu_cnt==4'b1000 || alu_cnt==4'b1001) && (state==IDLE || state==DONE).
  - Other alu_cnt values, or start while in RUN, are ignored with no state change.
- stall = busy | accept (combinational), so the issuing instruction freezes in its accept cycle.
- IDLE/DONE on accept: latch op_a, op_b and the opcode; clear counter and div_zero.
  - Normal case: go to RUN.
  - DIV with op_b==0: go directly to DONE with lo={WIDTH{1'b1}}, hi=op_a, div_zero=1.
- DONE without accept: go to IDLE.
- done=1 only in DONE, for exactly one cycle.
- hi, lo and div_zero hold until the next accept.
- RUN performs one iteration per cycle. The counter increments each cycle; after WIDTH RUN cycles, go to DONE.
  - MUL: if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator. Then shift the accumulator and multiplier right by 1. Carry-out from the add is kept (WIDTH+1-bit adder).
  - DIV: shift {rem, dividend} left by 1 and trial-subtract divisor from rem.
    - Non-negative result: keep it and shift in quotient bit 1.
    - Otherwise: restore and shift in 0.
- hi and lo update on the edge that enters DONE.
- Latency: accept in cycle 0, done in cycle WIDTH+1. Divide-by-zero: done in cycle 1.
- Back-to-back: an accept in the DONE cycle starts the next operation with no IDLE bubble.
- Reset mid-operation aborts the operation immediately; the partial result is discarded.
- Operands changing during RUN have no effect.

Optional Feature:
- MULDIV_SIGNED_EN defined: operands are two's complement.
  - Magnitudes are taken at accept and the iterative core runs unsigned.
  - The product is negated if the operand signs differ.
  - The quotient is negated if the signs differ; it truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Negation is applied on the edge entering DONE; latency is unchanged.
  - Divide-by-zero result is unchanged (lo=all ones, hi=op_a).
  - Most-negative / -1 gives lo=most-negative, hi=0, div_zero=0.
- MULDIV_SIGNED_EN undefined: all operations are unsigned and no sign logic is synthesized.

Test Plan (WIDTH=16):
- MUL 300*500 (0x012C, 0x01F4), start in cycle 0 -> stall=1 in cycles 0-16, done=1 in cycle 17, hi=0x0002, lo=0x49F0.
- DIV 1000/7 -> done in cycle 17, lo=0x008E, hi=0x0006, div_zero=0.
- DIV 0x1234/0 -> done in cycle 1, lo=0xFFFF, hi=0x1234, div_zero=1. A following MUL 3*4 clears div_zero and gives lo=0x000C, hi=0.
- Accept a MUL in the DONE cycle of a DIV -> second done exactly 17 cycles later. A start with alu_cnt=4'b0101 in IDLE -> stall=0, no state change. A start during RUN is ignored and the result is unaffected.
- Assert rst in cycle 8 of a MUL -> busy, done, hi and lo go to 0 immediately. A new MUL 2*3 then completes with lo=0x0006.
- MUL 0xFFFA*0x0007:
  - Unsigned -> hi=0x0006, lo=0xFFD6.
  - With MULDIV_SIGNED_EN -> hi=0xFFFF, lo=0xFFD6; DIV 0xFFF9/0x0002 -> lo=0xFFFD, hi=0xFFFF.
